// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// Takes an asynchronous, idle-high serial line and produces one-cycle byte
// strobes (o_wr with o_data) or framing-error strobes (o_frame_err).
// Bit timing comes from a down-counting baud counter. The counter is first
// loaded with a half period so that every later sample lands in the middle
// of its bit.
// A stop bit sampled low is treated as a possible break. The receiver then
// parks in BREAK until the line returns high, so a held-low line gives one
// error strobe and no repeated start detections.

module uart_rx #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd217
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    output logic       o_wr,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_busy
);

    // Half a bit period positions the first sample mid start bit.
    // Both reload values are kept at 24 bits so no legal divider truncates.
    localparam logic [23:0] HALF      = CLOCKS_PER_BAUD >> 1;
    localparam logic [23:0] HALF_LOAD = HALF - 24'd1;
    localparam logic [23:0] BAUD_LOAD = CLOCKS_PER_BAUD - 24'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [23:0] counter;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    // Two-flop synchronizer on the serial pin. It resets to the idle level
    // so that leaving reset cannot look like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM. It also owns the baud counter, the bit index, the shift
    // register and every registered output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            counter     <= 24'd0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            o_wr        <= 1'b0;
            o_data      <= 8'h00;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_wr        <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        counter <= HALF_LOAD;
                        o_busy  <= 1'b1;
                        state   <= S_START;
                    end
                end

                S_START: begin
                    if (counter == 24'd0) begin
                        if (rx_s) begin
                            o_busy <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            counter <= BAUD_LOAD;
                            bit_idx <= 3'd0;
                            state   <= S_DATA;
                        end
                    end else begin
                        counter <= counter - 24'd1;
                    end
                end

                S_DATA: begin
                    if (counter == 24'd0) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        counter <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        counter <= counter - 24'd1;
                    end
                end

                S_STOP: begin
                    if (counter == 24'd0) begin
                        if (rx_s) begin
                            o_data <= shreg;
                            o_wr   <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end else begin
                        counter <= counter - 24'd1;
                    end
                end

                S_BREAK: begin
                    if (rx_s) begin
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Two receivers are instantiated: a 217-clock divider and the minimum
// divider of 4. Both are fed by a bit-level serializer in the bench.
// Strobe times are predicted from the frame start with plain arithmetic:
// the FSM sees the start bit 3 clocks after the line falls (2 sync flops,
// then the FSM edge), and the byte strobe lands HALF + 9 bit periods later.

module tb_uart_rx;

    localparam int CPB_S  = 217;
    localparam int HALF_S = CPB_S / 2;
    localparam int CPB_F  = 4;
    localparam int HALF_F = CPB_F / 2;

    typedef struct {
        int         at_edge;
        logic [7:0] data;
        logic       busy;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_slow;
    logic       rx_fast;
    logic       wr_s, ferr_s, busy_s;
    logic [7:0] data_s;
    logic       wr_f, ferr_f, busy_f;
    logic [7:0] data_f;

    int  edge_cnt = 0;
    int  checks = 0;
    int  errors = 0;
    int  overlap_cnt = 0;
    int  busy_fall_s = 0;
    logic busy_prev_s = 1'b0;
    logic [7:0] last_byte_s = 8'h00;

    ev_t wr_q_s[$];
    ev_t wr_q_f[$];
    int  fe_q_s[$];
    int  fe_q_f[$];

    uart_rx #(.CLOCKS_PER_BAUD(24'd217)) dut_slow (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_uart_rx   (rx_slow),
        .o_wr        (wr_s),
        .o_data      (data_s),
        .o_frame_err (ferr_s),
        .o_busy      (busy_s)
    );

    uart_rx #(.CLOCKS_PER_BAUD(24'd4)) dut_fast (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_uart_rx   (rx_fast),
        .o_wr        (wr_f),
        .o_data      (data_f),
        .o_frame_err (ferr_f),
        .o_busy      (busy_f)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used as the timebase for all predicted strobe times.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Strobe monitor: records every event on the falling edge, away from the
    // active edge.
    always @(negedge clk) begin
        ev_t ev;
        if (wr_s) begin
            ev.at_edge = edge_cnt; ev.data = data_s; ev.busy = busy_s;
            wr_q_s.push_back(ev);
        end
        if (wr_f) begin
            ev.at_edge = edge_cnt; ev.data = data_f; ev.busy = busy_f;
            wr_q_f.push_back(ev);
        end
        if (ferr_s) fe_q_s.push_back(edge_cnt);
        if (ferr_f) fe_q_f.push_back(edge_cnt);
        if ((wr_s && ferr_s) || (wr_f && ferr_f)) overlap_cnt++;
        if (busy_prev_s && !busy_s) busy_fall_s++;
        busy_prev_s = busy_s;
    end

    function automatic int expected_strobe(input bit fast, input int start);
        if (fast) return start + 3 + HALF_F + 9 * CPB_F;
        return start + 3 + HALF_S + 9 * CPB_S;
    endfunction

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input bit fast, input logic v);
        if (fast) rx_fast = v;
        else rx_slow = v;
    endtask

    // Serializes one 8N1 frame LSB first. The line is left at the stop level.
    task automatic send_byte(input bit fast, input logic [7:0] b, input bit stop_val,
                             output int start_edge);
        int cpb;
        cpb = fast ? CPB_F : CPB_S;
        set_line(fast, 1'b0);
        start_edge = edge_cnt;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(fast, b[i]);
            repeat (cpb) @(negedge clk);
        end
        set_line(fast, stop_val);
        repeat (cpb) @(negedge clk);
    endtask

    task automatic clear_queues();
        wr_q_s.delete(); wr_q_f.delete(); fe_q_s.delete(); fe_q_f.delete();
    endtask

    task automatic test_reset();
        rx_slow = 1'b1;
        rx_fast = 1'b1;
        reset   = 1'b1;
        idle(3);
        checks++;
        if ({wr_s, ferr_s, busy_s, data_s} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_slow: got %h expected %h", {wr_s, ferr_s, busy_s, data_s}, 11'h000);
        end
        checks++;
        if ({wr_f, ferr_f, busy_f, data_f} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_fast: got %h expected %h", {wr_f, ferr_f, busy_f, data_f}, 11'h000);
        end
        reset = 1'b0;
        idle(5);
    endtask

    task automatic test_single_byte();
        int st;
        clear_queues();
        send_byte(1'b0, 8'h48, 1'b1, st);
        idle(20);
        checks++;
        if (wr_q_s.size() !== 1) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d expected 1", wr_q_s.size());
        end
        if (wr_q_s.size() >= 1) begin
            checks++;
            if (wr_q_s[0].data !== 8'h48) begin
                errors++;
                $display("[TB] FAIL single_data: got %h expected 48", wr_q_s[0].data);
            end
            checks++;
            if (wr_q_s[0].at_edge !== expected_strobe(1'b0, st)) begin
                errors++;
                $display("[TB] FAIL single_time: got %0d expected %0d", wr_q_s[0].at_edge, expected_strobe(1'b0, st));
            end
        end
        checks++;
        if (fe_q_s.size() !== 0) begin
            errors++;
            $display("[TB] FAIL single_ferr: got %0d expected 0", fe_q_s.size());
        end
        last_byte_s = 8'h48;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rom [16];
        int starts [16];
        int fall0;
        rom = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F,
                8'h72, 8'h6C, 8'h64, 8'h21, 8'h21, 8'h21, 8'h0D, 8'h0A};
        clear_queues();
        fall0 = busy_fall_s;
        for (int i = 0; i < 16; i++) send_byte(1'b0, rom[i], 1'b1, starts[i]);
        idle(20);
        checks++;
        if (wr_q_s.size() !== 16) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 16", wr_q_s.size());
        end
        for (int i = 0; i < 16 && i < wr_q_s.size(); i++) begin
            checks++;
            if (wr_q_s[i].data !== rom[i] || wr_q_s[i].at_edge !== expected_strobe(1'b0, starts[i])
                || wr_q_s[i].busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_byte%0d: got %h@%0d busy=%b expected %h@%0d busy=0", i,
                         wr_q_s[i].data, wr_q_s[i].at_edge, wr_q_s[i].busy, rom[i], expected_strobe(1'b0, starts[i]));
            end
        end
        checks++;
        if (busy_fall_s - fall0 !== 16) begin
            errors++;
            $display("[TB] FAIL b2b_busy_drops: got %0d expected 16", busy_fall_s - fall0);
        end
        checks++;
        if (fe_q_s.size() !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_ferr: got %0d expected 0", fe_q_s.size());
        end
        last_byte_s = rom[15];
    endtask

    task automatic test_glitch();
        int m, st;
        idle(10);
        clear_queues();
        set_line(1'b0, 1'b0);
        m = edge_cnt;
        wait_edge(m + 3);
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_busy_rise: got %b expected 1", busy_s);
        end
        wait_edge(m + 50);
        set_line(1'b0, 1'b1);
        wait_edge(m + 3 + HALF_S - 1);
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_busy_hold: got %b expected 1", busy_s);
        end
        wait_edge(m + 3 + HALF_S);
        checks++;
        if (busy_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_busy_drop: got %b expected 0", busy_s);
        end
        idle(300);
        checks++;
        if (wr_q_s.size() !== 0 || fe_q_s.size() !== 0) begin
            errors++;
            $display("[TB] FAIL glitch_strobes: got wr=%0d ferr=%0d expected 0/0", wr_q_s.size(), fe_q_s.size());
        end
        send_byte(1'b0, 8'h55, 1'b1, st);
        idle(20);
        checks++;
        if (wr_q_s.size() !== 1 || (wr_q_s.size() == 1 && (wr_q_s[0].data !== 8'h55
            || wr_q_s[0].at_edge !== expected_strobe(1'b0, st)))) begin
            errors++;
            $display("[TB] FAIL glitch_recover: got count=%0d expected one 55 at %0d", wr_q_s.size(),
                     expected_strobe(1'b0, st));
        end
        last_byte_s = 8'h55;
    endtask

    task automatic test_frame_error();
        int st, m2;
        idle(10);
        clear_queues();
        send_byte(1'b0, 8'hA5, 1'b0, st);
        idle(3000);
        checks++;
        if (fe_q_s.size() !== 1 || (fe_q_s.size() == 1 && fe_q_s[0] !== expected_strobe(1'b0, st))) begin
            errors++;
            $display("[TB] FAIL ferr_pulse: got count=%0d expected one at %0d", fe_q_s.size(), expected_strobe(1'b0, st));
        end
        checks++;
        if (wr_q_s.size() !== 0) begin
            errors++;
            $display("[TB] FAIL ferr_no_wr: got %0d expected 0", wr_q_s.size());
        end
        checks++;
        if (data_s !== last_byte_s) begin
            errors++;
            $display("[TB] FAIL ferr_data_hold: got %h expected %h", data_s, last_byte_s);
        end
        set_line(1'b0, 1'b1);
        m2 = edge_cnt;
        wait_edge(m2 + 2);
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL break_busy_hold: got %b expected 1", busy_s);
        end
        wait_edge(m2 + 3);
        checks++;
        if (busy_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL break_busy_drop: got %b expected 0", busy_s);
        end
        idle(50);
        send_byte(1'b0, 8'h0F, 1'b1, st);
        idle(20);
        checks++;
        if (wr_q_s.size() !== 1 || (wr_q_s.size() == 1 && (wr_q_s[0].data !== 8'h0F
            || wr_q_s[0].at_edge !== expected_strobe(1'b0, st)))) begin
            errors++;
            $display("[TB] FAIL ferr_recover: got count=%0d expected one 0f at %0d", wr_q_s.size(),
                     expected_strobe(1'b0, st));
        end
        checks++;
        if (fe_q_s.size() !== 1) begin
            errors++;
            $display("[TB] FAIL ferr_single: got %0d expected 1", fe_q_s.size());
        end
        last_byte_s = 8'h0F;
    endtask

    task automatic test_reset_mid_frame();
        int m, st;
        idle(10);
        clear_queues();
        m = edge_cnt;
        fork
            send_byte(1'b0, 8'hFF, 1'b1, st);
            begin
                wait_edge(m + 5 * CPB_S + 100);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                checks++;
                if ({wr_s, ferr_s, busy_s, data_s} !== 11'h000) begin
                    errors++;
                    $display("[TB] FAIL midreset_outputs: got %h expected %h", {wr_s, ferr_s, busy_s, data_s}, 11'h000);
                end
            end
        join
        idle(300);
        checks++;
        if (wr_q_s.size() !== 0 || fe_q_s.size() !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_strobes: got wr=%0d ferr=%0d expected 0/0", wr_q_s.size(), fe_q_s.size());
        end
        send_byte(1'b0, 8'h3C, 1'b1, st);
        idle(20);
        checks++;
        if (wr_q_s.size() !== 1 || (wr_q_s.size() == 1 && (wr_q_s[0].data !== 8'h3C
            || wr_q_s[0].at_edge !== expected_strobe(1'b0, st)))) begin
            errors++;
            $display("[TB] FAIL midreset_recover: got count=%0d expected one 3c at %0d", wr_q_s.size(),
                     expected_strobe(1'b0, st));
        end
    endtask

    task automatic test_fast_stream();
        logic [7:0] bytes [3];
        int starts [3];
        bytes = '{8'h00, 8'hFF, 8'h81};
        idle(10);
        clear_queues();
        for (int i = 0; i < 3; i++) send_byte(1'b1, bytes[i], 1'b1, starts[i]);
        idle(60);
        checks++;
        if (wr_q_f.size() !== 3) begin
            errors++;
            $display("[TB] FAIL fast_count: got %0d expected 3", wr_q_f.size());
        end
        for (int i = 0; i < 3 && i < wr_q_f.size(); i++) begin
            checks++;
            if (wr_q_f[i].data !== bytes[i] || wr_q_f[i].at_edge !== expected_strobe(1'b1, starts[i])) begin
                errors++;
                $display("[TB] FAIL fast_byte%0d: got %h@%0d expected %h@%0d", i, wr_q_f[i].data,
                         wr_q_f[i].at_edge, bytes[i], expected_strobe(1'b1, starts[i]));
            end
            if (i > 0) begin
                checks++;
                if (wr_q_f[i].at_edge - wr_q_f[i-1].at_edge !== 40) begin
                    errors++;
                    $display("[TB] FAIL fast_spacing%0d: got %0d expected 40", i,
                             wr_q_f[i].at_edge - wr_q_f[i-1].at_edge);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        ev_t exp_q[$];
        ev_t ev;
        int st;
        logic [7:0] b;
        idle(10);
        clear_queues();
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            send_byte(1'b1, b, 1'b1, st);
            ev.at_edge = expected_strobe(1'b1, st); ev.data = b; ev.busy = 1'b0;
            exp_q.push_back(ev);
            idle($urandom_range(0, 6));
        end
        idle(60);
        checks++;
        if (wr_q_f.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL rand_count: got %0d expected %0d", wr_q_f.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_q_f.size(); i++) begin
            checks++;
            if (wr_q_f[i].data !== exp_q[i].data || wr_q_f[i].at_edge !== exp_q[i].at_edge
                || wr_q_f[i].busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_byte%0d: got %h@%0d busy=%b expected %h@%0d busy=0", i, wr_q_f[i].data,
                         wr_q_f[i].at_edge, wr_q_f[i].busy, exp_q[i].data, exp_q[i].at_edge);
            end
        end
        checks++;
        if (fe_q_f.size() !== 0) begin
            errors++;
            $display("[TB] FAIL rand_ferr: got %0d expected 0", fe_q_f.size());
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL strobe_overlap: got %0d expected 0", overlap_cnt);
        end
    endtask

    // Test sequence.
    initial begin
        reset   = 1'b1;
        rx_slow = 1'b1;
        rx_fast = 1'b1;
        @(negedge clk);
        $display("[TB] starting uart_rx tests");
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_fast_stream();
        test_random_stream();
        test_no_overlap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
